mult_share_arbiter: RTL and testbench

//  Shares one combinational 4x4 multiplier (signed/unsigned, 8-bit product) between
//  N_REQ requesters. Round-robin arbitration, valid/ready handshakes on every side,

---
 rtl/mult_share_arbiter_pkg.sv | 12 +
 rtl/mult_share_arbiter_rr.sv | 29 ++
 rtl/mult_share_arbiter.sv | 90 +++++++++
 tb/tb_mult_share_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared sizing and state encoding for the multiplier-sharing arbiter.
package mult_share_pkg;
  localparam int N_REQ  = 4;
  localparam int OP_W   = 4;
  localparam int PROD_W = 2 * OP_W;
  localparam int ID_W   = $clog2(N_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          vld
);
  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (en && !vld && req[j]) begin
        vld      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one external combinational multiplier among N_REQ
// requesters, with a single registered result slot tagged by requester index.
module mult_share_arbiter #(
  parameter int N_REQ = mult_share_pkg::N_REQ,
  parameter int OP_W  = mult_share_pkg::OP_W,
  parameter int ID_W  = mult_share_pkg::ID_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_a,
  input  logic [N_REQ*OP_W-1:0]   req_b,
  input  logic [N_REQ-1:0]        req_signed,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  output logic                    mul_signed,
  input  logic [2*OP_W-1:0]       mul_product,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [2*OP_W-1:0]       rsp_product
);
  import mult_share_pkg::*;

  state_t                         state, state_nxt;
  logic [ID_W-1:0]                rr_ptr, gnt_idx;
  logic [N_REQ-1:0]               gnt;
  logic                           gnt_vld, can_issue;
  logic [N_REQ-1:0][OP_W-1:0]     lane_a, lane_b;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_a[i] = req_a[i*OP_W +: OP_W];
    assign lane_b[i] = req_b[i*OP_W +: OP_W];
  end

  assign rsp_valid = (state == FULL);
  // A full slot being drained this cycle frees it for a new result.
  assign can_issue = (state == EMPTY) || rsp_ready;

  // rst_n gates the grant so no handshake can complete while reset is held.
  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (can_issue & rst_n),
    .grant (gnt),
    .idx   (gnt_idx),
    .vld   (gnt_vld)
  );

  assign req_ready = gnt;

  // One-hot OR mux; all-zero with no grant keeps the multiplier inputs quiet.
  always_comb begin
    mul_a      = '0;
    mul_b      = '0;
    mul_signed = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        mul_a      = mul_a | lane_a[i];
        mul_b      = mul_b | lane_b[i];
        mul_signed = mul_signed | req_signed[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (gnt_vld)
      state_nxt = FULL;
    else if (rsp_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      rsp_id      <= '0;
      rsp_product <= '0;
      rr_ptr      <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        rsp_product <= mul_product;
        rsp_id      <= gnt_idx;
        rr_ptr      <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level model.
module tb_mult_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, req_signed;
  logic [15:0] req_a, req_b;
  logic [3:0]  mul_a, mul_b;
  logic        mul_signed;
  logic [7:0]  mul_product;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_product;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
    .mul_a(mul_a), .mul_b(mul_b), .mul_signed(mul_signed),
    .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product)
  );

  // Stand-in for the shared multiplier: sign/zero-extend and keep low 8 bits.
  logic [7:0] ext_a, ext_b;
  assign ext_a       = {{4{mul_signed & mul_a[3]}}, mul_a};
  assign ext_b       = {{4{mul_signed & mul_b[3]}}, mul_b};
  assign mul_product = ext_a * ext_b;

  function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b,
                                          input logic s);
    int x, y;
    x = (s && a >= 8) ? int'(a) - 16 : int'(a);
    y = (s && b >= 8) ? int'(b) - 16 : int'(b);
    return 8'(x * y);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] a, b;
    logic [3:0]  sgn;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_id;
    logic [7:0]  exp_prod;
  } vec_t;

  vec_t tbl[6];

  // random-phase model state
  logic [3:0] pend;
  logic [3:0] oa[4], ob[4];
  logic       os[4];
  bit         m_full;
  logic [1:0] m_id;
  logic [7:0] m_prod;
  int         m_ptr;

  initial begin
    // rr pointer sequence through the table: 0 ->3 ->2 ->0 ->1 ->1 ->0
    tbl[0] = '{4'b0100, 16'h0700, 16'h0300, 4'b0000, 4'b0100, 2'd2, 8'd21};
    tbl[1] = '{4'b0010, 16'h00F0, 16'h0030, 4'b0010, 4'b0010, 2'd1, 8'hFD};
    tbl[2] = '{4'b1011, 16'h5123, 16'h5456, 4'b0000, 4'b1000, 2'd3, 8'h19};
    tbl[3] = '{4'b0011, 16'h123F, 16'h456F, 4'b0000, 4'b0001, 2'd0, 8'hE1};
    tbl[4] = '{4'b0001, 16'h7778, 16'h1118, 4'b0001, 4'b0001, 2'd0, 8'h40};
    tbl[5] = '{4'b1000, 16'h7321, 16'h8456, 4'b1000, 4'b1000, 2'd3, 8'hC8};

    // reset with every requester asking
    rst_n = 1'b0; req_valid = 4'b1111; req_a = 16'hFFFF; req_b = 16'hFFFF;
    req_signed = 4'b0000; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_product", 32'(rsp_product), 0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0000;
    @(negedge clk);

    // table: one transaction each from an empty slot
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      req_valid = tbl[v].valid; req_a = tbl[v].a; req_b = tbl[v].b;
      req_signed = tbl[v].sgn; rsp_ready = 1'b1;
      #1;
      check($sformatf("tbl%0d_req_ready", v), 32'(req_ready), 32'(tbl[v].exp_ready));
      check($sformatf("tbl%0d_mul_a", v), 32'(mul_a), 32'(tbl[v].a[tbl[v].exp_id*4 +: 4]));
      check($sformatf("tbl%0d_mul_b", v), 32'(mul_b), 32'(tbl[v].b[tbl[v].exp_id*4 +: 4]));
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check($sformatf("tbl%0d_rsp_valid", v), 32'(rsp_valid), 1);
      check($sformatf("tbl%0d_rsp_id", v), 32'(rsp_id), 32'(tbl[v].exp_id));
      check($sformatf("tbl%0d_rsp_product", v), 32'(rsp_product), 32'(tbl[v].exp_prod));
    end
    @(negedge clk);

    // round robin with all requesters valid; lane i product = 2*(i+1)
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req_valid = 4'b1111; req_a = 16'h4321; req_b = 16'h2222;
        req_signed = 4'b0000; rsp_ready = 1'b1;
      end
      #1;
      check($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        check($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 1);
        check($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'((k - 1) % 4));
        check($sformatf("rr%0d_rsp_product", k), 32'(rsp_product), 32'(2 * ((k - 1) % 4 + 1)));
      end
    end

    // backpressure: slot holds id 0 while the consumer stalls
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 0);
      check($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 1);
      check($sformatf("bp%0d_rsp_id", k), 32'(rsp_id), 0);
      check($sformatf("bp%0d_rsp_product", k), 32'(rsp_product), 2);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_drain_req_ready", 32'(req_ready), 32'(4'b0010));
    check("bp_drain_mul_a", 32'(mul_a), 2);
    @(negedge clk);
    #1;
    check("bp_refill_rsp_id", 32'(rsp_id), 1);
    check("bp_refill_rsp_product", 32'(rsp_product), 4);
    req_valid = 4'b1000;

    // async reset while holding a result from requester 3
    @(negedge clk);
    req_valid = 4'b0000; rsp_ready = 1'b0;
    #1;
    check("ar_full_rsp_id", 32'(rsp_id), 3);
    check("ar_full_rsp_product", 32'(rsp_product), 8);
    #2 rst_n = 1'b0;
    #1;
    check("ar_rsp_valid", 32'(rsp_valid), 0);
    check("ar_rsp_id", 32'(rsp_id), 0);
    check("ar_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    #1;
    check("ar_release_req_ready", 32'(req_ready), 32'(4'b0001));
    req_valid = 4'b0010;

    // reset with rr_ptr parked at 2 must bring it back to 0
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    check("ar2_rsp_id", 32'(rsp_id), 1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b1111;
    #1;
    check("ar2_ptr_cleared", 32'(req_ready), 32'(4'b0001));
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the transaction model
    pend = '0; m_full = 0; m_id = '0; m_prod = '0; m_ptr = 0;
    for (int i = 0; i < 4; i++) begin oa[i] = '0; ob[i] = '0; os[i] = 1'b0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      bit can;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(1, 0) == 1) begin
            pend[i] = 1'b1;
            oa[i] = 4'($urandom_range(15, 0));
            ob[i] = 4'($urandom_range(15, 0));
            os[i] = 1'($urandom_range(1, 0));
          end
        end else if ($urandom_range(7, 0) == 0) begin
          pend[i] = 1'b0;
        end
        req_a[i*4 +: 4] = oa[i];
        req_b[i*4 +: 4] = ob[i];
        req_signed[i]   = os[i];
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(3, 0) != 0);
      #1;
      can = !m_full || rsp_ready;
      g = -1;
      if (can)
        for (int k = 0; k < 4; k++)
          if (g < 0 && pend[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      check("rnd_req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 0);
      check("rnd_mul_a", 32'(mul_a), (g >= 0) ? 32'(oa[g]) : 0);
      check("rnd_mul_signed", 32'(mul_signed), (g >= 0) ? 32'(os[g]) : 0);
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full) begin
        check("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
        check("rnd_rsp_product", 32'(rsp_product), 32'(m_prod));
      end
      if (g >= 0) begin
        m_full  = 1;
        m_id    = 2'(g);
        m_prod  = ref_prod(oa[g], ob[g], os[g]);
        m_ptr   = (g + 1) % 4;
        pend[g] = 1'b0;
      end else if (m_full && rsp_ready) begin
        m_full = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
